// File: rtl/csel_add_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-select adder.
// Optional signed-overflow output is enabled with CSEL_ADD_OVF_EN.
package csel_add_pkg;

    localparam int unsigned CSEL_WIDTH     = 32;
    localparam int unsigned CSEL_SEG_WIDTH = 8;

    typedef logic [CSEL_SEG_WIDTH-1:0] seg_t;

    // One pipeline stage's payload at the default geometry.
    typedef struct packed {
        logic                  valid;
        logic                  carry;
        logic [CSEL_WIDTH-1:0] sum_lo;
        logic [CSEL_WIDTH-1:0] a_hi;
        logic [CSEL_WIDTH-1:0] b_hi;
        logic                  ovf;
    } stage_t;

    function automatic int unsigned num_seg(input int unsigned width, input int unsigned seg_width);
        if (seg_width == 0 || width < seg_width) return 1;
        return width / seg_width;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned seg_width,
                                     input int unsigned sub_blk);
        if (seg_width == 0 || sub_blk == 0 || width < seg_width) return 1'b0;
        return ((width % seg_width) == 0) && ((seg_width % sub_blk) == 0);
    endfunction

endpackage

// File: rtl/csel_segment.sv
// Combinational carry-select segment: each sub-block precomputes sums for
// carry-in 0 and 1, and the sub-block carry chain picks one.
module csel_segment #(
    parameter int unsigned SEG_WIDTH = 8,
    parameter int unsigned SUB_BLK   = 4
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [SEG_WIDTH-1:0] sum,
    output logic                 cout,
    output logic                 c_msb_in
);

    localparam int unsigned NUM_BLK = SEG_WIDTH / SUB_BLK;
    localparam int unsigned BLK_W   = SUB_BLK + 1;

    logic [NUM_BLK:0] c;

    assign c[0] = cin;

    for (genvar j = 0; j < NUM_BLK; j++) begin : g_blk
        logic [SUB_BLK:0] s0;
        logic [SUB_BLK:0] s1;

        assign s0 = {1'b0, a[j*SUB_BLK +: SUB_BLK]} + {1'b0, b[j*SUB_BLK +: SUB_BLK]};
        assign s1 = {1'b0, a[j*SUB_BLK +: SUB_BLK]} + {1'b0, b[j*SUB_BLK +: SUB_BLK]} + BLK_W'(1);

        assign sum[j*SUB_BLK +: SUB_BLK] = c[j] ? s1[SUB_BLK-1:0] : s0[SUB_BLK-1:0];
        assign c[j+1]                    = c[j] ? s1[SUB_BLK]     : s0[SUB_BLK];
    end

    assign cout = c[NUM_BLK];
    // Carry into the MSB recovered from the sum bit; feeds signed-overflow detection.
    assign c_msb_in = sum[SEG_WIDTH-1] ^ a[SEG_WIDTH-1] ^ b[SEG_WIDTH-1];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Stallable pipelined carry-select adder/subtractor, one segment per stage.
// Define CSEL_ADD_OVF_EN to add the registered signed-overflow output out_ovf.
module pipelined_csel_adder
    import csel_add_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SEG_WIDTH = 8,
    parameter int unsigned SUB_BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
`ifdef CSEL_ADD_OVF_EN
    output logic             out_ovf,
`endif
    output logic             out_cout
);

    localparam int unsigned NUM_SEG = num_seg(WIDTH, SEG_WIDTH);
    localparam int unsigned LAST    = NUM_SEG - 1;

    if (!params_ok(WIDTH, SEG_WIDTH, SUB_BLK)) begin : g_param_err
        $error("pipelined_csel_adder: WIDTH must be a multiple of SEG_WIDTH and SEG_WIDTH of SUB_BLK");
    end

    logic [NUM_SEG:0]   adv;
    logic [NUM_SEG-1:0] v_q;
    logic [NUM_SEG-1:0] src_v;
    logic [NUM_SEG-1:0] src_c;
    logic [WIDTH-1:0]   src_a [NUM_SEG];
    logic [WIDTH-1:0]   src_b [NUM_SEG];
    logic [WIDTH-1:0]   src_s [NUM_SEG];

    // Advance chain: a stage may load when it is empty or its successor advances.
    always_comb begin
        adv          = '0;
        adv[NUM_SEG] = out_ready;
        for (int k = int'(LAST); k >= 0; k--) begin
            adv[k] = !v_q[k] || adv[k+1];
        end
    end

    assign in_ready = adv[0];

    assign src_v[0] = in_valid;
    assign src_a[0] = in_a;
    assign src_b[0] = in_sub ? ~in_b : in_b;
    assign src_c[0] = in_sub ? ~in_cin : in_cin;
    assign src_s[0] = '0;

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
        logic [SEG_WIDTH-1:0] seg_sum;
        logic                 seg_cout;
        logic                 seg_cmsb;
        logic                 cmsb_unused;
        logic [WIDTH-1:0]     nsum;
        logic [WIDTH-1:0]     sum_r;
        logic                 v_r;
        logic                 c_r;
        logic                 load;

        csel_segment #(
            .SEG_WIDTH (SEG_WIDTH),
            .SUB_BLK   (SUB_BLK)
        ) u_seg (
            .a        (src_a[k][k*SEG_WIDTH +: SEG_WIDTH]),
            .b        (src_b[k][k*SEG_WIDTH +: SEG_WIDTH]),
            .cin      (src_c[k]),
            .sum      (seg_sum),
            .cout     (seg_cout),
            .c_msb_in (seg_cmsb)
        );

        // Only the MSB segment's carry-into-MSB is meaningful.
        assign cmsb_unused = seg_cmsb;
        assign load        = adv[k] && src_v[k];

        always_comb begin
            nsum                                = src_s[k];
            nsum[k*SEG_WIDTH +: SEG_WIDTH]      = seg_sum;
        end

        // Payload only updates on a real beat so idle outputs never toggle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r   <= 1'b0;
                c_r   <= 1'b0;
                sum_r <= '0;
            end else begin
                if (adv[k]) v_r <= src_v[k];
                if (load) begin
                    c_r   <= seg_cout;
                    sum_r <= nsum;
                end
            end
        end

        assign v_q[k] = v_r;

        if (k < LAST) begin : g_fwd
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (load) begin
                    a_r <= src_a[k];
                    b_r <= src_b[k];
                end
            end

            assign src_v[k+1] = v_r;
            assign src_c[k+1] = c_r;
            assign src_s[k+1] = sum_r;
            assign src_a[k+1] = a_r;
            assign src_b[k+1] = b_r;
        end else begin : g_out
            assign out_valid = v_r;
            assign out_sum   = sum_r;
            assign out_cout  = c_r;
`ifdef CSEL_ADD_OVF_EN
            logic ovf_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (load) begin
                    ovf_r <= seg_cout ^ seg_cmsb;
                end
            end

            assign out_ovf = ovf_r;
`endif
        end
    end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder: directed table, random burst,
// stall, async reset mid-flight, and an 8-bit single-stage instance.
module tb_pipelined_csel_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    logic        in8_valid = 1'b0;
    logic        in8_ready;
    logic [7:0]  in8_a = '0;
    logic [7:0]  in8_b = '0;
    logic        in8_cin = 1'b0;
    logic        in8_sub = 1'b0;
    logic        out8_valid;
    logic        out8_ready = 1'b1;
    logic [7:0]  out8_sum;
    logic        out8_cout;
    logic        out8_ovf;

    pipelined_csel_adder #(.WIDTH(32), .SEG_WIDTH(8), .SUB_BLK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef CSEL_ADD_OVF_EN
        .out_ovf(out_ovf),
`endif
        .out_cout(out_cout)
    );

    pipelined_csel_adder #(.WIDTH(8), .SEG_WIDTH(8), .SUB_BLK(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in8_valid), .in_ready(in8_ready),
        .in_a(in8_a), .in_b(in8_b), .in_cin(in8_cin), .in_sub(in8_sub),
        .out_valid(out8_valid), .out_ready(out8_ready), .out_sum(out8_sum),
`ifdef CSEL_ADD_OVF_EN
        .out_ovf(out8_ovf),
`endif
        .out_cout(out8_cout)
    );

`ifndef CSEL_ADD_OVF_EN
    assign out_ovf  = 1'b0;
    assign out8_ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    res_t exp_q[$];
    vec_t vecs[9];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   burst_pops = 0;
    int   first_pop = 0;
    int   last_pop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic on the mapped operands.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        res_t        r;
        logic [31:0] bp;
        logic        c0;
        logic [32:0] full;
        bp     = sub ? ~b : b;
        c0     = sub ? ~cin : cin;
        full   = {1'b0, a} + {1'b0, bp} + 33'(c0);
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (a[31] == bp[31]) && (full[31] != a[31]);
        return r;
    endfunction

    // Scoreboard: every valid output must match the oldest accepted beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    chk("sb_sum", 64'(out_sum), 64'(exp_q[0].sum));
                    chk("sb_cout", 64'(out_cout), 64'(exp_q[0].cout));
`ifdef CSEL_ADD_OVF_EN
                    chk("sb_ovf", 64'(out_ovf), 64'(exp_q[0].ovf));
`endif
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (burst_pops == 0) first_pop = cyc;
                        last_pop = cyc;
                        burst_pops++;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, output int waited);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        chk("send_accept", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic apply_vec(input int idx);
        int w;
        int n;
        send(vecs[idx].a, vecs[idx].b, vecs[idx].cin, vecs[idx].sub, w);
        n = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            n++;
        end
        chk($sformatf("vec%0d_latency", idx), 64'(n), 64'(4));
        chk($sformatf("vec%0d_sum", idx), 64'(out_sum), 64'(vecs[idx].sum));
        chk($sformatf("vec%0d_cout", idx), 64'(out_cout), 64'(vecs[idx].cout));
`ifdef CSEL_ADD_OVF_EN
        chk($sformatf("vec%0d_ovf", idx), 64'(out_ovf), 64'(vecs[idx].ovf));
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        @(posedge clk);
        #1;
        chk(name, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int          w;
        logic [11:0] iv;
        logic [7:0]  bp8;
        logic        c08;
        logic [8:0]  full8;
        logic        ovf8;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0};
        vecs[5] = '{32'h00000010, 32'h00000003, 1'b1, 1'b1, 32'h0000000C, 1'b1, 1'b0};
        vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[8] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};

        #23;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_sum", 64'(out_sum), 64'(0));
        chk("rst_out_cout", 64'(out_cout), 64'(0));
        chk("rst_out_ovf", 64'(out_ovf), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) apply_vec(i);

        // Back-to-back random burst with the consumer always ready.
        burst_pops = 0;
        for (int i = 0; i < 100; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
            chk("burst_no_wait", 64'(w), 64'(0));
        end
        drain("burst_drain");
        chk("burst_pop_count", 64'(burst_pops), 64'(100));
        chk("burst_one_per_cycle", 64'(last_pop - first_pop), 64'(99));

        // Consumer stall in the middle of a stream.
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
                end
            end
            begin
                repeat (8) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (10) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", 64'(in_ready), 64'(0));
                chk("stall_out_valid", 64'(out_valid), 64'(1));
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("stall_drain");

        // Asynchronous reset with the pipeline full.
        for (int i = 0; i < 4; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
        end
        chk("prerst_out_valid", 64'(out_valid), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_out_sum", 64'(out_sum), 64'(0));
        chk("arst_out_cout", 64'(out_cout), 64'(0));
        chk("arst_out_ovf", 64'(out_ovf), 64'(0));
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_vec(4);
        drain("post_rst_drain");

        // Single-stage 8-bit instance: all A x cin x sub with random B.
        in8_valid = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            iv      = 12'(i);
            in8_a   = iv[7:0];
            in8_b   = 8'($urandom);
            in8_cin = iv[8];
            in8_sub = iv[9];
            bp8     = in8_sub ? ~in8_b : in8_b;
            c08     = in8_sub ? ~in8_cin : in8_cin;
            full8   = {1'b0, in8_a} + {1'b0, bp8} + 9'(c08);
            ovf8    = (in8_a[7] == bp8[7]) && (full8[7] != in8_a[7]);
            @(posedge clk);
            #1;
            chk("w8_valid", 64'(out8_valid), 64'(1));
            chk("w8_sum", 64'(out8_sum), 64'(full8[7:0]));
            chk("w8_cout", 64'(out8_cout), 64'(full8[8]));
`ifdef CSEL_ADD_OVF_EN
            chk("w8_ovf", 64'(out8_ovf), 64'(ovf8));
`endif
        end
        in8_valid = 1'b0;

        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
